// File: rtl/missile_hit_detect.sv
// missile_hit_detect
//   Checks the player missile against the enemy formation once per frame.
//   Owns the enemy alive bitmap and the saturating score. Sits between the
//   missile block and the sprite/HUD draw logic.
//
//   Once per frame tick, if a missile is in flight, the block scans one enemy
//   per Clk. The first live enemy whose box overlaps the missile box is killed.
//   The lowest index wins, and at most one enemy is killed per frame.
//
// Optional feature (compile-time macro ROW_SCORE_EN):
//   defined   : a kill scores PTS*(ROWS-row), so the top row is worth most
//   undefined : every kill scores PTS
//
// Ports
//   Clk            in   system clock
//   Reset          in   synchronous, active-high reset
//   frame_clk      in   frame tick level; a rising edge marks a new frame
//   MISSILE1_X/Y   in   missile top-left position, 10 bits each
//   missile_1      in   missile in flight
//   GRID_X/Y       in   formation origin (enemy 0 top-left), 10 bits each
//   new_wave       in   one-Clk pulse that revives all enemies
//   missile1_hit   out  missile struck an enemy this frame; held until next tick
//   enemy_alive    out  bit i = row i/COLS, col i%COLS alive
//   score          out  accumulated score, saturating at 16'hFFFF
//   wave_clear     out  all enemies dead
module missile_hit_detect #(
  parameter int ROWS      = 4,
  parameter int COLS      = 8,
  parameter int ENEMY_W   = 16,
  parameter int ENEMY_H   = 12,
  parameter int SPACE_X   = 24,
  parameter int SPACE_Y   = 18,
  parameter int MISSILE_W = 2,
  parameter int MISSILE_H = 6,
  parameter int PTS       = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [9:0]           MISSILE1_X,
  input  logic [9:0]           MISSILE1_Y,
  input  logic                 missile_1,
  input  logic [9:0]           GRID_X,
  input  logic [9:0]           GRID_Y,
  input  logic                 new_wave,
  output logic                 missile1_hit,
  output logic [ROWS*COLS-1:0] enemy_alive,
  output logic [15:0]          score,
  output logic                 wave_clear
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  // Adds b to a, clamping the result at the 16-bit maximum.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [2:0]       fsync_q, fsync_d;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [9:0]       mx_q, mx_d, my_q, my_d, gx_q, gx_d, gy_q, gy_d;
  logic             hit_q, hit_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [15:0]      score_q, score_d;

  logic             tick_s;
  logic             hit_s;
  int               row_s, col_s;
  logic [10:0]      ex_s, ey_s, mx11_s, my11_s;
  logic [15:0]      pts_s;

  // Frame tick: bits 0..1 form the two-flop synchroniser, bit 2 is used for edge detection.
  always_comb begin
    fsync_d = {fsync_q[1:0], frame_clk};
    tick_s  = fsync_q[1] & ~fsync_q[2];
  end

  // Geometry for the enemy under the scan index. The 11-bit math cannot wrap.
  always_comb begin
    row_s  = int'(idx_q) / COLS;
    col_s  = int'(idx_q) % COLS;
    ex_s   = {1'b0, gx_q} + 11'(col_s * SPACE_X);
    ey_s   = {1'b0, gy_q} + 11'(row_s * SPACE_Y);
    mx11_s = {1'b0, mx_q};
    my11_s = {1'b0, my_q};
    hit_s  = alive_q[idx_q]
             && (mx11_s < ex_s + 11'(ENEMY_W)) && (ex_s < mx11_s + 11'(MISSILE_W))
             && (my11_s < ey_s + 11'(ENEMY_H)) && (ey_s < my11_s + 11'(MISSILE_H));
`ifdef ROW_SCORE_EN
    pts_s  = 16'(PTS * (ROWS - row_s));
`else
    pts_s  = 16'(PTS);
`endif
  end

  // Scan state machine: next state, latched operands, hit flag, bitmap and score.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mx_d    = mx_q;
    my_d    = my_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    hit_d   = hit_q;
    alive_d = alive_q;
    score_d = score_q;
    case (state_q)
      S_IDLE: begin
        if (tick_s) begin
          // The hit flag lives for a whole frame so the slow missile block sees it once.
          hit_d = 1'b0;
          if (missile_1) begin
            mx_d    = MISSILE1_X;
            my_d    = MISSILE1_Y;
            gx_d    = GRID_X;
            gy_d    = GRID_Y;
            idx_d   = {IDX_W{1'b0}};
            state_d = S_SCAN;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (hit_s) begin
          state_d = S_KILL;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_KILL: begin
        alive_d[idx_q] = 1'b0;
        hit_d          = 1'b1;
        score_d        = sat_add16(score_q, pts_s);
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A new wave overrides a same-cycle kill clear; the kill still scores.
    if (new_wave) begin
      alive_d = {N{1'b1}};
    end else begin
      alive_d = alive_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsync_q <= 3'b000;
      state_q <= S_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      mx_q    <= 10'd0;
      my_q    <= 10'd0;
      gx_q    <= 10'd0;
      gy_q    <= 10'd0;
      hit_q   <= 1'b0;
      alive_q <= {N{1'b1}};
      score_q <= 16'd0;
    end else begin
      fsync_q <= fsync_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      hit_q   <= hit_d;
      alive_q <= alive_d;
      score_q <= score_d;
    end
  end

  assign missile1_hit = hit_q;
  assign enemy_alive  = alive_q;
  assign score        = score_q;
  assign wave_clear   = (alive_q == {N{1'b0}});

endmodule

// File: tb/tb_missile_hit_detect.sv
module tb_missile_hit_detect;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  MISSILE1_X = 10'd0, MISSILE1_Y = 10'd0, GRID_X = 10'd0, GRID_Y = 10'd0;
  logic        missile_1 = 1'b0;
  logic        new_wave = 1'b0;
  logic        missile1_hit;
  logic [31:0] enemy_alive;
  logic [15:0] score;
  logic        wave_clear;

  missile_hit_detect dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .MISSILE1_X(MISSILE1_X), .MISSILE1_Y(MISSILE1_Y), .missile_1(missile_1),
    .GRID_X(GRID_X), .GRID_Y(GRID_Y), .new_wave(new_wave),
    .missile1_hit(missile1_hit), .enemy_alive(enemy_alive),
    .score(score), .wave_clear(wave_clear)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;
  int gx = 100;
  int gy = 40;

  // Reference model: formation state as plain values
  bit [31:0] m_alive;
  int        m_score;
  bit        m_hit;

  function automatic int model_find(input int mx, input int my);
    for (int i = 0; i < 32; i++) begin
      int ex, ey;
      ex = gx + (i % 8) * 24;
      ey = gy + (i / 8) * 18;
      if (m_alive[i] && mx < ex + 16 && ex < mx + 2 && my < ey + 12 && ey < my + 6)
        return i;
    end
    return -1;
  endfunction

  task automatic model_frame(input int mx, input int my, input bit active, input bit nw);
    int i, pts;
    m_hit = 0;
    if (active) begin
      i = model_find(mx, my);
      if (i >= 0) begin
        m_hit = 1;
        m_alive[i] = 1'b0;
`ifdef ROW_SCORE_EN
        pts = 10 * (4 - i / 8);
`else
        pts = 10;
`endif
        m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
      end
    end
    if (nw) m_alive = '1;
  endtask

  task automatic model_reset();
    m_alive = '1;
    m_score = 0;
    m_hit = 0;
  endtask

  // One frame: raise frame_clk, let the scan complete, update the model.
  // hit_at = first cycle (after the frame_clk rise) at which missile1_hit reads 1, or -1.
  task automatic do_frame(input int mx, input int my, input bit active, input bit nw, output int hit_at);
    @(negedge Clk);
    MISSILE1_X = mx[9:0];
    MISSILE1_Y = my[9:0];
    GRID_X = gx[9:0];
    GRID_Y = gy[9:0];
    missile_1 = active;
    new_wave = nw;
    frame_clk = 1'b1;
    hit_at = -1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge Clk);
      if (c == 4) frame_clk = 1'b0;
      if (hit_at < 0 && missile1_hit === 1'b1) hit_at = c;
    end
    missile_1 = 1'b0;
    new_wave = 1'b0;
    model_frame(mx, my, active, nw);
  endtask

  task automatic pulse_new_wave();
    @(negedge Clk);
    new_wave = 1'b1;
    @(negedge Clk);
    new_wave = 1'b0;
    m_alive = '1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    checks++; if (enemy_alive !== 32'hFFFF_FFFF) $display("FAIL reset_alive got %h want ffffffff", enemy_alive); else passes++;
    checks++; if (score !== 16'd0) $display("FAIL reset_score got %0d want 0", score); else passes++;
    checks++; if (missile1_hit !== 1'b0) $display("FAIL reset_hit got %b want 0", missile1_hit); else passes++;
    checks++; if (wave_clear !== 1'b0) $display("FAIL reset_wave_clear got %b want 0", wave_clear); else passes++;
  endtask

  task automatic test_no_missile();
    int h;
    for (int k = 0; k < 3; k++) begin
      do_frame(107, 50, 1'b0, 1'b0, h);
      checks++; if (missile1_hit !== 1'b0 || h != -1) $display("FAIL idle_hit got %b want 0", missile1_hit); else passes++;
    end
    checks++; if (score !== 16'd0) $display("FAIL idle_score got %0d want 0", score); else passes++;
    checks++; if (enemy_alive !== 32'hFFFF_FFFF) $display("FAIL idle_alive got %h want ffffffff", enemy_alive); else passes++;
  endtask

  task automatic test_single_hit();
    int h;
    do_frame(107, 50, 1'b1, 1'b0, h);
    // two sync stages + IDLE->SCAN + SCAN idx0 -> KILL -> hit registered
    checks++; if (h < 0 || h > 5) $display("FAIL hit_latency got %0d want 1..5", h); else passes++;
    checks++; if (enemy_alive[0] !== 1'b0 || enemy_alive !== m_alive) $display("FAIL hit_alive got %h want %h", enemy_alive, m_alive); else passes++;
    checks++; if (score !== m_score[15:0]) $display("FAIL hit_score got %0d want %0d", score, m_score); else passes++;
    checks++; if (missile1_hit !== 1'b1) $display("FAIL hit_flag got %b want 1", missile1_hit); else passes++;
    do_frame(0, 0, 1'b0, 1'b0, h);
    checks++; if (missile1_hit !== 1'b0) $display("FAIL hit_clear got %b want 0", missile1_hit); else passes++;
  endtask

  task automatic test_dead_enemy();
    int h;
    do_frame(131, 50, 1'b1, 1'b0, h);
    checks++; if (enemy_alive !== m_alive || enemy_alive[1] !== 1'b0) $display("FAIL e1_alive got %h want %h", enemy_alive, m_alive); else passes++;
    checks++; if (score !== m_score[15:0]) $display("FAIL e1_score got %0d want %0d", score, m_score); else passes++;
    do_frame(131, 50, 1'b1, 1'b0, h);
    checks++; if (missile1_hit !== 1'b0) $display("FAIL e1_repeat_hit got %b want 0", missile1_hit); else passes++;
    checks++; if (score !== m_score[15:0]) $display("FAIL e1_repeat_score got %0d want %0d", score, m_score); else passes++;
  endtask

  task automatic test_edge();
    int h;
    pulse_new_wave();
    do_frame(98, 50, 1'b1, 1'b0, h);
    checks++; if (missile1_hit !== 1'b0 || enemy_alive !== 32'hFFFF_FFFF) $display("FAIL edge_miss hit %b alive %h want 0 ffffffff", missile1_hit, enemy_alive); else passes++;
    do_frame(99, 50, 1'b1, 1'b0, h);
    checks++; if (missile1_hit !== 1'b1 || enemy_alive !== 32'hFFFF_FFFE) $display("FAIL edge_hit hit %b alive %h want 1 fffffffe", missile1_hit, enemy_alive); else passes++;
    checks++; if (score !== m_score[15:0]) $display("FAIL edge_score got %0d want %0d", score, m_score); else passes++;
  endtask

  task automatic test_reset_mid_scan();
    int h;
    do_frame(131, 50, 1'b1, 1'b0, h);
    @(negedge Clk);
    MISSILE1_X = 10'd600; MISSILE1_Y = 10'd600;
    missile_1 = 1'b1;
    frame_clk = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 4) frame_clk = 1'b0;
    end
    Reset = 1'b1;
    missile_1 = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    checks++; if (score !== 16'd0) $display("FAIL midscan_score got %0d want 0", score); else passes++;
    checks++; if (enemy_alive !== 32'hFFFF_FFFF) $display("FAIL midscan_alive got %h want ffffffff", enemy_alive); else passes++;
    checks++; if (missile1_hit !== 1'b0) $display("FAIL midscan_hit got %b want 0", missile1_hit); else passes++;
    // FSM must be idle: a fresh frame behaves exactly like the first hit after reset
    do_frame(107, 50, 1'b1, 1'b0, h);
    checks++; if (h < 0 || h > 5 || enemy_alive !== m_alive) $display("FAIL midscan_idle lat %0d alive %h want <=5 %h", h, enemy_alive, m_alive); else passes++;
  endtask

  task automatic test_wave_clear();
    int h;
    for (int i = 0; i < 32; i++)
      do_frame(gx + (i % 8) * 24 + 4, gy + (i / 8) * 18 + 2, 1'b1, 1'b0, h);
    checks++; if (wave_clear !== 1'b1 || enemy_alive !== 32'd0) $display("FAIL clear_flag wc %b alive %h want 1 0", wave_clear, enemy_alive); else passes++;
    checks++; if (score !== m_score[15:0]) $display("FAIL clear_score got %0d want %0d", score, m_score); else passes++;
`ifndef ROW_SCORE_EN
    checks++; if (score !== 16'd320) $display("FAIL clear_score320 got %0d want 320", score); else passes++;
`endif
    pulse_new_wave();
    @(negedge Clk);
    checks++; if (wave_clear !== 1'b0 || enemy_alive !== 32'hFFFF_FFFF) $display("FAIL newwave wc %b alive %h want 0 ffffffff", wave_clear, enemy_alive); else passes++;
    checks++; if (score !== m_score[15:0]) $display("FAIL newwave_score got %0d want %0d", score, m_score); else passes++;
  endtask

  task automatic test_new_wave_vs_kill();
    int h;
    do_frame(gx + 24 * 3 + 1, gy + 18 + 1, 1'b1, 1'b1, h);
    checks++; if (enemy_alive !== 32'hFFFF_FFFF) $display("FAIL nw_kill_alive got %h want ffffffff", enemy_alive); else passes++;
    checks++; if (missile1_hit !== 1'b1 || score !== m_score[15:0]) $display("FAIL nw_kill_score hit %b score %0d want 1 %0d", missile1_hit, score, m_score); else passes++;
  endtask

  task automatic test_random();
    int h, mx, my;
    bit act;
    for (int k = 0; k < 120; k++) begin
      gx = $urandom_range(700, 0);
      gy = $urandom_range(900, 0);
      mx = gx + $urandom_range(210, 0) - 10; if (mx < 0) mx = 0;
      my = gy + $urandom_range(80, 0) - 10; if (my < 0) my = 0;
      act = ($urandom_range(99, 0) < 85);
      if ($urandom_range(9, 0) == 0 || m_alive == 0) pulse_new_wave();
      do_frame(mx, my, act, 1'b0, h);
      checks++;
      if (missile1_hit !== m_hit || enemy_alive !== m_alive || score !== m_score[15:0] || wave_clear !== (m_alive == 0))
        $display("FAIL rand_%0d (%0d,%0d g %0d,%0d) hit %b/%b alive %h/%h score %0d/%0d wc %b",
                 k, mx, my, gx, gy, missile1_hit, m_hit, enemy_alive, m_alive, score, m_score, wave_clear);
      else passes++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_no_missile();
    test_single_hit();
    test_dead_enemy();
    test_edge();
    test_reset_mid_scan();
    test_wave_clear();
    test_new_wave_vs_kill();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
